// File: rtl/spmv_pkg.sv
// rtl/spmv_pkg.sv - shared state type, drain length and lane-mask helper for the SpMV MAC channel
package spmv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      OUT    = 2'd3
   } spmv_mac_state_e;

   localparam int unsigned SPMV_DRAIN_CYCLES = 2;

   // A lane is live while its index is below the number of nonzeros still owed by the row.
   function automatic logic spmv_lane_mask_bit(input logic [31:0] remaining, input logic [31:0] lane);
      return lane < remaining;
   endfunction

endpackage

// File: rtl/spmv_lane_reduce.sv
// rtl/spmv_lane_reduce.sv - masked per-lane product registers and sign-extended lane sum
module spmv_lane_reduce
   import spmv_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int DATA_W = 32,
   parameter int OUT_W  = 67
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [LANES-1:0]          lane_mask,
   input  logic [LANES*DATA_W-1:0]   mat,
   input  logic [LANES*DATA_W-1:0]   vec,
   output logic [OUT_W-1:0]          lane_sum
);

   localparam int PROD_W = 2 * DATA_W;

   logic [LANES-1:0][PROD_W-1:0] prod_q;
   logic [LANES-1:0][PROD_W-1:0] prod_d;

   function automatic logic [PROD_W-1:0] smul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic signed [PROD_W-1:0] ax;
      logic signed [PROD_W-1:0] bx;
      ax = {{DATA_W{a[DATA_W-1]}}, a};
      bx = {{DATA_W{b[DATA_W-1]}}, b};
      return ax * bx;
   endfunction

   // Masked lanes load zero so stale or garbage data never reaches the sum.
   always_comb begin
      prod_d = prod_q;
      if (load) begin
         for (int i = 0; i < LANES; i++) begin
            prod_d[i] = lane_mask[i] ? smul(mat[i*DATA_W +: DATA_W], vec[i*DATA_W +: DATA_W]) : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
      end else begin
         prod_q <= prod_d;
      end
   end

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_sum = lane_sum + {{(OUT_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
      end
   end

endmodule

// File: rtl/spmv_mac_channel.sv
// rtl/spmv_mac_channel.sv - one-row-at-a-time SpMV multiply-accumulate channel with sticky overflow
module spmv_mac_channel
   import spmv_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int DATA_W = 32,
   parameter int ACC_W  = 64,
   parameter int LEN_W  = 16,
   parameter int ROW_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      row_val,
   output logic                      row_rdy,
   input  logic [ROW_W-1:0]          row_id,
   input  logic [LEN_W-1:0]          row_len,
   input  logic                      elem_val,
   output logic                      elem_rdy,
   input  logic [LANES*DATA_W-1:0]   elem_mat,
   input  logic [LANES*DATA_W-1:0]   elem_vec,
   output logic                      res_val,
   input  logic                      res_rdy,
   output logic [ROW_W-1:0]          res_row_id,
   output logic [ACC_W-1:0]          res_sum,
   output logic                      res_ovf
);

   localparam int             SUM_W      = ACC_W + $clog2(LANES) + 1;
   localparam logic [LEN_W:0] LANES_L    = LANES[LEN_W:0];
   localparam logic [1:0]     DRAIN_LAST = 2'(SPMV_DRAIN_CYCLES - 1);

   spmv_mac_state_e   state_q, state_d;
   logic [1:0]        drain_cnt_q, drain_cnt_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic              s1_vld_q, s1_vld_d;
   logic [ROW_W-1:0]  row_id_q, row_id_d;
   logic [ROW_W-1:0]  res_row_id_q, res_row_id_d;
   logic [ACC_W-1:0]  res_sum_q, res_sum_d;
   logic              res_ovf_q, res_ovf_d;

   logic              lane_load;
   logic [LANES-1:0]  lane_mask;
   logic [SUM_W-1:0]  lane_sum;
   logic [SUM_W-1:0]  full_sum;
   logic              sum_ovf;

   assign lane_load = (state_q == STREAM) && elem_val;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lane_mask[i] = spmv_lane_mask_bit(32'(rem_q), 32'(i));
      end
   end

   spmv_lane_reduce #(
      .LANES  (LANES),
      .DATA_W (DATA_W),
      .OUT_W  (SUM_W)
   ) u_lane_reduce (
      .clk       (clk),
      .rst       (rst),
      .load      (lane_load),
      .lane_mask (lane_mask),
      .mat       (elem_mat),
      .vec       (elem_vec),
      .lane_sum  (lane_sum)
   );

   // Overflow: the guard bits above the ACC_W sign bit disagree with it.
   assign full_sum = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q} + lane_sum;
   assign sum_ovf  = (|full_sum[SUM_W-1:ACC_W-1]) & ~(&full_sum[SUM_W-1:ACC_W-1]);

   always_comb begin
      state_d      = state_q;
      drain_cnt_d  = drain_cnt_q;
      rem_d        = rem_q;
      acc_d        = acc_q;
      ovf_d        = ovf_q;
      s1_vld_d     = 1'b0;
      row_id_d     = row_id_q;
      res_row_id_d = res_row_id_q;
      res_sum_d    = res_sum_q;
      res_ovf_d    = res_ovf_q;

      if (s1_vld_q) begin
         acc_d = full_sum[ACC_W-1:0];
         ovf_d = ovf_q | sum_ovf;
      end

      case (state_q)
         IDLE: begin
            if (row_val) begin
               row_id_d = row_id;
               rem_d    = row_len;
               acc_d    = '0;
               ovf_d    = 1'b0;
               if (row_len == '0) begin
                  state_d      = OUT;
                  res_row_id_d = row_id;
                  res_sum_d    = '0;
                  res_ovf_d    = 1'b0;
               end else begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (elem_val) begin
               s1_vld_d = 1'b1;
               if ({1'b0, rem_q} <= LANES_L) begin
                  rem_d       = '0;
                  state_d     = DRAIN;
                  drain_cnt_d = '0;
               end else begin
                  rem_d = rem_q - LANES_L[LEN_W-1:0];
               end
            end
         end
         DRAIN: begin
            // acc holds the last beat by the final drain cycle, so the result is captured here.
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d      = OUT;
               res_row_id_d = row_id_q;
               res_sum_d    = acc_q;
               res_ovf_d    = ovf_q;
            end else begin
               drain_cnt_d = drain_cnt_q + 2'd1;
            end
         end
         OUT: begin
            if (res_rdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         drain_cnt_q  <= '0;
         rem_q        <= '0;
         acc_q        <= '0;
         ovf_q        <= 1'b0;
         s1_vld_q     <= 1'b0;
         row_id_q     <= '0;
         res_row_id_q <= '0;
         res_sum_q    <= '0;
         res_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_cnt_q  <= drain_cnt_d;
         rem_q        <= rem_d;
         acc_q        <= acc_d;
         ovf_q        <= ovf_d;
         s1_vld_q     <= s1_vld_d;
         row_id_q     <= row_id_d;
         res_row_id_q <= res_row_id_d;
         res_sum_q    <= res_sum_d;
         res_ovf_q    <= res_ovf_d;
      end
   end

   assign row_rdy    = (state_q == IDLE);
   assign elem_rdy   = (state_q == STREAM);
   assign res_val    = (state_q == OUT);
   assign res_row_id = res_row_id_q;
   assign res_sum    = res_sum_q;
   assign res_ovf    = res_ovf_q;

endmodule

// File: tb/tb_spmv_mac_channel.sv
// tb/tb_spmv_mac_channel.sv - randomized self-checking bench for spmv_mac_channel
module tb_spmv_mac_channel;

   localparam int LANES  = 4;
   localparam int DATA_W = 32;
   localparam int ACC_W  = 64;
   localparam int LEN_W  = 16;
   localparam int ROW_W  = 32;
   localparam int BW     = LANES * DATA_W;
   localparam int BUDGET = 200;

   logic              clk = 1'b0;
   logic              rst;
   logic              row_val;
   logic              row_rdy;
   logic [ROW_W-1:0]  row_id;
   logic [LEN_W-1:0]  row_len;
   logic              elem_val;
   logic              elem_rdy;
   logic [BW-1:0]     elem_mat;
   logic [BW-1:0]     elem_vec;
   logic              res_val;
   logic              res_rdy;
   logic [ROW_W-1:0]  res_row_id;
   logic [ACC_W-1:0]  res_sum;
   logic              res_ovf;

   int checks = 0;
   int errors = 0;

   logic [BW-1:0]     mat_q[$];
   logic [BW-1:0]     vec_q[$];
   logic [ACC_W-1:0]  exp_sum;
   logic              exp_ovf;
   int                lat;

   spmv_mac_channel #(
      .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .ROW_W(ROW_W)
   ) dut (
      .clk(clk), .rst(rst),
      .row_val(row_val), .row_rdy(row_rdy), .row_id(row_id), .row_len(row_len),
      .elem_val(elem_val), .elem_rdy(elem_rdy), .elem_mat(elem_mat), .elem_vec(elem_vec),
      .res_val(res_val), .res_rdy(res_rdy), .res_row_id(res_row_id), .res_sum(res_sum), .res_ovf(res_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   function automatic logic [BW-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
      return {d, c, b, a};
   endfunction

   function automatic logic [31:0] rand_word(input int mode);
      int sel;
      if (mode == 0) return $urandom;
      if (mode == 1) return 32'($urandom_range(0, 15)) - 32'd8;
      sel = $urandom_range(0, 2);
      if (sel == 0) return 32'h8000_0000;
      if (sel == 1) return 32'h7FFF_FFFF;
      return 32'hFFFF_FFFF;
   endfunction

   task automatic fill_row(input int len, input int mode);
      logic [BW-1:0] m, v;
      mat_q.delete();
      vec_q.delete();
      for (int b = 0; b < (len + LANES - 1) / LANES; b++) begin
         for (int i = 0; i < LANES; i++) begin
            m[i*DATA_W +: DATA_W] = rand_word(mode);
            v[i*DATA_W +: DATA_W] = rand_word(mode);
         end
         mat_q.push_back(m);
         vec_q.push_back(v);
      end
   endtask

   // Reference: exact 128-bit arithmetic per beat; the accumulator wraps to ACC_W and any
   // out-of-range beat total latches the overflow flag for the rest of the row.
   task automatic model_row(input int len);
      logic signed [127:0] acc, beat, full, lim_hi, lim_lo;
      logic signed [DATA_W-1:0] m, v;
      lim_hi = (128'sd1 <<< (ACC_W - 1)) - 128'sd1;
      lim_lo = -(128'sd1 <<< (ACC_W - 1));
      acc = 0;
      exp_ovf = 1'b0;
      for (int b = 0; b < mat_q.size(); b++) begin
         beat = 0;
         for (int i = 0; i < LANES; i++) begin
            if (b * LANES + i < len) begin
               m = mat_q[b][i*DATA_W +: DATA_W];
               v = vec_q[b][i*DATA_W +: DATA_W];
               beat = beat + 128'(m) * 128'(v);
            end
         end
         full = acc + beat;
         if (full > lim_hi || full < lim_lo) exp_ovf = 1'b1;
         acc = $signed(full[ACC_W-1:0]);
      end
      exp_sum = acc[ACC_W-1:0];
   endtask

   // Sends one descriptor plus the queued beats, then waits for res_val; lat counts edges
   // from the last input transfer to the first cycle res_val is seen.
   task automatic run_row(input logic [ROW_W-1:0] id, input int len, input bit gaps);
      int n;
      row_id  = id;
      row_len = LEN_W'(len);
      row_val = 1'b1;
      n = 0;
      while (!row_rdy && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= BUDGET) begin
         checks++; errors++;
         $display("FAIL row_rdy_timeout: row_rdy=%0b required 1", row_rdy);
      end
      @(posedge clk); #1;
      row_val = 1'b0;
      row_id  = $urandom;
      row_len = LEN_W'($urandom);
      for (int b = 0; b < mat_q.size(); b++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               elem_val = 1'b0;
               elem_mat = {LANES{$urandom}};
               elem_vec = {LANES{$urandom}};
               @(posedge clk); #1;
            end
         end
         elem_val = 1'b1;
         elem_mat = mat_q[b];
         elem_vec = vec_q[b];
         checks++;
         if (elem_rdy !== 1'b1 || row_rdy !== 1'b0) begin
            errors++;
            $display("FAIL stream_rdy: elem_rdy=%0b row_rdy=%0b required 1/0", elem_rdy, row_rdy);
         end
         @(posedge clk); #1;
      end
      elem_val = 1'b0;
      elem_mat = {LANES{$urandom}};
      lat = 0;
      while (res_val !== 1'b1 && lat < BUDGET) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      res_rdy = 1'b1;
      @(posedge clk); #1;
      res_rdy = 1'b0;
      checks++;
      if (row_rdy !== 1'b1 || res_val !== 1'b0) begin
         errors++;
         $display("FAIL release: row_rdy=%0b res_val=%0b required 1/0", row_rdy, res_val);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; row_val = 1'b0; elem_val = 1'b0; res_rdy = 1'b0;
      row_id = '0; row_len = '0; elem_mat = '0; elem_vec = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (row_rdy !== 1'b1) begin errors++; $display("FAIL reset_row_rdy: got %0b required 1", row_rdy); end
      checks++; if (elem_rdy !== 1'b0) begin errors++; $display("FAIL reset_elem_rdy: got %0b required 0", elem_rdy); end
      checks++; if (res_val !== 1'b0) begin errors++; $display("FAIL reset_res_val: got %0b required 0", res_val); end
      checks++; if (res_row_id !== '0) begin errors++; $display("FAIL reset_res_row_id: got %0h required 0", res_row_id); end
      checks++; if (res_sum !== '0) begin errors++; $display("FAIL reset_res_sum: got %0h required 0", res_sum); end
      checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL reset_res_ovf: got %0b required 0", res_ovf); end
   endtask

   task automatic test_zero_len();
      mat_q.delete(); vec_q.delete();
      run_row(32'd7, 0, 1'b0);
      checks++; if (lat != 0) begin errors++; $display("FAIL zero_len_latency: got %0d required 0", lat); end
      checks++;
      if (res_row_id !== 32'd7 || res_sum !== '0 || res_ovf !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_result: id=%0d sum=%0h ovf=%0b required 7/0/0", res_row_id, res_sum, res_ovf);
      end
      release_result();
   endtask

   task automatic test_full_beat();
      mat_q = '{pack4(1, 2, 3, 4)};
      vec_q = '{pack4(5, 6, 7, 8)};
      run_row(32'd11, 4, 1'b0);
      checks++; if (lat != 2) begin errors++; $display("FAIL full_beat_latency: got %0d required 2", lat); end
      checks++;
      if (res_row_id !== 32'd11 || res_sum !== 64'd70 || res_ovf !== 1'b0) begin
         errors++;
         $display("FAIL full_beat_result: id=%0d sum=%0d ovf=%0b required 11/70/0", res_row_id, res_sum, res_ovf);
      end
      release_result();
   endtask

   task automatic test_partial();
      mat_q = '{pack4(1, 1, 1, 1), pack4(3, 3, 32'h7FFF_FFFF, 32'h7FFF_FFFF)};
      vec_q = '{pack4(2, 2, 2, 2), pack4(3, 3, 32'h7FFF_FFFF, 32'h7FFF_FFFF)};
      run_row(32'd12, 6, 1'b0);
      checks++; if (lat != 2) begin errors++; $display("FAIL partial_latency: got %0d required 2", lat); end
      checks++;
      if (res_sum !== 64'd26 || res_ovf !== 1'b0) begin
         errors++;
         $display("FAIL partial_result: sum=%0d ovf=%0b required 26/0", res_sum, res_ovf);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      mat_q = '{pack4(1, 2, 3, 4)};
      vec_q = '{pack4(5, 6, 7, 8)};
      run_row(32'h55, 4, 1'b0);
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (res_val !== 1'b1 || res_row_id !== 32'h55 || res_sum !== 64'd70 || res_ovf !== 1'b0 ||
             row_rdy !== 1'b0 || elem_rdy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold c%0d: val=%0b id=%0h sum=%0d ovf=%0b row_rdy=%0b elem_rdy=%0b required 1/55/70/0/0/0",
                     c, res_val, res_row_id, res_sum, res_ovf, row_rdy, elem_rdy);
         end
         @(posedge clk); #1;
      end
      release_result();
   endtask

   task automatic test_overflow();
      mat_q = '{pack4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000)};
      vec_q = '{pack4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000)};
      run_row(32'd20, 4, 1'b0);
      checks++;
      if (res_sum !== 64'd0 || res_ovf !== 1'b1) begin
         errors++;
         $display("FAIL overflow_result: sum=%0h ovf=%0b required 0/1", res_sum, res_ovf);
      end
      release_result();
      mat_q = '{pack4(1, 9, 9, 9)};
      vec_q = '{pack4(1, 9, 9, 9)};
      run_row(32'd21, 1, 1'b0);
      checks++;
      if (res_sum !== 64'd1 || res_ovf !== 1'b0) begin
         errors++;
         $display("FAIL overflow_cleared: sum=%0h ovf=%0b required 1/0", res_sum, res_ovf);
      end
      release_result();
   endtask

   task automatic test_reset_mid();
      row_id = 32'd30; row_len = 16'd12; row_val = 1'b1;
      @(posedge clk); #1;
      row_val = 1'b0;
      elem_val = 1'b1; elem_mat = pack4(5, 5, 5, 5); elem_vec = pack4(5, 5, 5, 5);
      @(posedge clk); #1;
      elem_val = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (row_rdy !== 1'b1 || elem_rdy !== 1'b0 || res_val !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_idle: row_rdy=%0b elem_rdy=%0b res_val=%0b required 1/0/0", row_rdy, elem_rdy, res_val);
      end
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         checks++;
         if (res_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_result c%0d: res_val=%0b required 0", c, res_val);
         end
      end
      fill_row(4, 1);
      model_row(4);
      run_row(32'd31, 4, 1'b0);
      checks++;
      if (res_row_id !== 32'd31 || res_sum !== exp_sum || res_ovf !== exp_ovf) begin
         errors++;
         $display("FAIL reset_mid_fresh: id=%0d sum=%0h ovf=%0b required 31/%0h/%0b", res_row_id, res_sum, res_ovf, exp_sum, exp_ovf);
      end
      release_result();
   endtask

   task automatic test_random_rows();
      logic [ROW_W-1:0] id;
      int len, mode, stall;
      for (int r = 0; r < 40; r++) begin
         id   = $urandom;
         len  = $urandom_range(0, 21);
         mode = $urandom_range(0, 2);
         fill_row(len, mode);
         model_row(len);
         run_row(id, len, 1'($urandom_range(0, 1)));
         checks++;
         if (lat != ((len == 0) ? 0 : 2)) begin
            errors++;
            $display("FAIL random_latency r%0d: got %0d required %0d", r, lat, (len == 0) ? 0 : 2);
         end
         stall = $urandom_range(0, 3);
         for (int c = 0; c <= stall; c++) begin
            checks++;
            if (res_val !== 1'b1 || res_row_id !== id || res_sum !== exp_sum || res_ovf !== exp_ovf || row_rdy !== 1'b0) begin
               errors++;
               $display("FAIL random_result r%0d len%0d: val=%0b id=%0h sum=%0h ovf=%0b required 1/%0h/%0h/%0b",
                        r, len, res_val, res_row_id, res_sum, res_ovf, id, exp_sum, exp_ovf);
            end
            if (c < stall) begin
               @(posedge clk); #1;
            end
         end
         release_result();
      end
   endtask

   task automatic test_max_len();
      fill_row(65535, 0);
      model_row(65535);
      run_row(32'hABCD, 65535, 1'b0);
      checks++;
      if (lat != 2 || res_row_id !== 32'hABCD || res_sum !== exp_sum || res_ovf !== exp_ovf) begin
         errors++;
         $display("FAIL max_len: lat=%0d id=%0h sum=%0h ovf=%0b required 2/abcd/%0h/%0b", lat, res_row_id, res_sum, res_ovf, exp_sum, exp_ovf);
      end
      release_result();
   endtask

   initial begin
      test_reset();
      test_zero_len();
      test_full_beat();
      test_partial();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_random_rows();
      test_max_len();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spmv_mac_channel.md
# spmv_mac_channel

Parametrised SpMV multiply-accumulate channel: accepts one row descriptor (row ID, nonzero count), consumes that row's matrix values and gathered vector values `LANES` at a time, and emits one signed dot-product per row with a sticky overflow flag. It sits between the fetch/decoder stage, which supplies descriptors and matrix values, and the BVB vector-gather stage on the input side, and the row-result writeback on the output side. It has a lane-count generalisation, row-length-driven lane masking, valid/ready backpressure and overflow detection.

## Interface
Parameters:
- `LANES`, 4, products per input beat (≥1, power of two)
- `DATA_W`, 32, signed matrix/vector element width
- `ACC_W`, 64, signed accumulator/result width (must be ≥ 2*DATA_W)
- `LEN_W`, 16, row-length width
- `ROW_W`, 32, row-ID width

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous reset, active-high.
- `row_val` in 1: descriptor valid.
- `row_rdy` out 1: descriptor ready.
- `row_id` in ROW_W: row index.
- `row_len` in LEN_W: number of nonzeros in the row.
- `elem_val` in 1: element beat valid.
- `elem_rdy` out 1: element beat ready.
- `elem_mat` in LANES*DATA_W: matrix values; lane i is bits [i*DATA_W +: DATA_W].
- `elem_vec` in LANES*DATA_W: vector values, same lane packing.
- `res_val` out 1: result valid.
- `res_rdy` in 1: result ready.
- `res_row_id` out ROW_W: row index of the result.
- `res_sum` out ACC_W: dot product, two's-complement wrapped.
- `res_ovf` out 1: an overflow occurred somewhere in this row.

## Operation
- FSM states:
  - IDLE: `row_rdy`=1. On `row_val`&&`row_rdy`, latch `row_id`, set `remaining`=`row_len`, and clear `acc` and `ovf`. If `row_len`==0 go to OUT, otherwise go to STREAM.
  - STREAM: `elem_rdy`=1. Each accepted beat masks lanes: lane i is active iff i < `remaining`, and inactive lanes contribute 0 whatever their data. Then `remaining` -= min(`remaining`, LANES). The beat that brings `remaining` to 0 moves the FSM to DRAIN.
  - DRAIN: 2 cycles, counted by a 2-bit counter, while the pipeline empties. Then go to OUT.
  - OUT: `res_val`=1. On `res_rdy`, go to IDLE.
- Datapath pipeline:
  - Stage 1 registers the masked signed products, each DATA_W×DATA_W → 2*DATA_W.
  - Stage 2 sign-extends the products, sums them through an adder tree, and adds the tree output to `acc` at full width, ACC_W+clog2(LANES)+1 bits.
  - `acc` takes the low ACC_W bits of that sum.
  - `ovf` is set, and stays set, if the full-width sum is outside the signed ACC_W range.
- Only one row is in flight. `row_rdy` and `elem_rdy` are never asserted together.
- Both `elem_rdy` and `row_rdy` are 0 in DRAIN and OUT. Upstream stalls.

## Timing
- Reset values: `row_rdy`=1 (IDLE), `elem_rdy`=0, `res_val`=0, `res_row_id`=0, `res_sum`=0, `res_ovf`=0. The pipeline valid bits, `remaining`, `acc` and `ovf` are all cleared.
- Latency:
  - Last beat accepted at edge T: `res_val`=1 from cycle T+3, after 2 DRAIN cycles.
  - `row_len`==0 descriptor accepted at edge T: `res_val`=1 from cycle T+1, with `res_sum`=0 and `res_ovf`=0.
- Throughput is 1 beat/cycle within a row. Per-row overhead is 1 descriptor cycle + 2 drain cycles + at least 1 result cycle.
- Handshakes:
  - A transfer occurs on a rising edge with val&&rdy.
  - `res_*` outputs stay stable while `res_val`&&!`res_rdy`.
  - Input val/data may change freely while rdy=0.
- Boundary conditions:
  - `row_len` that is an exact multiple of LANES: all lanes of the last beat are active.
  - `row_len` < LANES: one beat with a partial mask.
  - Maximum `row_len` (2^LEN_W−1) must work with no counter wrap.
  - Reset asserted in any state: the in-flight row is discarded, no result is produced, and the block is in IDLE on the cycle after `rst` deasserts.

## Structure
- Package `spmv_pkg`:
  - state enum `spmv_mac_state_e` {IDLE, STREAM, DRAIN, OUT}
  - `SPMV_DRAIN_CYCLES`=2
  - a function for lane-mask generation from `remaining`
- Sub-module `spmv_lane_reduce`: holds the stage-1 product registers and the masking, plus the combinational adder tree. It is parametrised by LANES and DATA_W and outputs a sign-extended lane sum.
- The top level holds the FSM, `remaining`, `acc`, `ovf` and the result registers.

## Test plan
- Zero-length row: `row_id`=7, `row_len`=0 → `res_val` at T+1, `res_row_id`=7, `res_sum`=0, `res_ovf`=0.
- Single full beat (LANES=4): mat {1,2,3,4}, vec {5,6,7,8}, `row_len`=4 → `res_sum`=70, `res_val` at T+3.
- Partial last beat: `row_len`=6; beat 1 mat {1,1,1,1} vec {2,2,2,2}; beat 2 lanes 0–1 = 3×3, lanes 2–3 = 0x7FFFFFFF → `res_sum`=26, the garbage lanes are ignored, and `res_ovf`=0.
- Backpressure: `res_rdy`=0 for 10 cycles → `res_*` stable, `row_rdy`=`elem_rdy`=0. After `res_rdy`=1, `row_rdy`=1 on the next cycle.
- Overflow (DATA_W=32, ACC_W=64): 4 lanes of (−2^31)×(−2^31) → `res_sum`=0 (wrapped 2^64), `res_ovf`=1. The following row of {1×1} → `res_ovf`=0.
- Reset mid-STREAM, after 1 of 3 beats → no `res_val` ever for that row, `row_rdy`=1 after reset. A fresh `row_len`=4 row then produces the correct sum.
